conv_channel_seq: RTL
=====================

CONV_CHANNEL_SEQ -- requirements
Module: conv_channel_seq

Interface
REQ-001 Parameters SHALL be: MAC_W, default 32, width of the signed per-channel MAC partial result; ACC_W, default 40, width of the signed channel accumulator.
REQ-002 Ports SHALL be: clk  in  1  sole clock; Reset  in  1  synchronous active-high reset.
REQ-003 start  in  1  one-cycle request to process num_kernels output kernels; ignored unless in S_IDLE.
REQ-004 num_kernels  in  9  output kernel count, sampled on accepted start.
REQ-005 CHANNEL_SIZE  in  9  input channels per kernel, sampled on accepted start.
REQ-006 load_BRAM_dina  out  1  one-cycle request to the kernel BRAM control unit to load one kernel.
REQ-007 done_loading_1ker  in  1  kernel BRAM control unit: last kernel word written.
REQ-008 update_BRAM_doutb  out  1  one-cycle request to advance the kernel BRAM read channel.
REQ-009 last_channel  in  1  kernel BRAM control unit: read channel wrapped past CHANNEL_SIZE-1.
REQ-010 mac_start  out  1  one-cycle start to the MAC array for the current channel.
REQ-011 mac_done  in  1  MAC array: mac_result valid this cycle.
REQ-012 mac_result  in  MAC_W  signed partial sum for one channel.
REQ-013 out_valid  out  1, out_ready  in  1, out_data  out  ACC_W: accumulated kernel result, valid/ready handshake.
REQ-014 busy  out  1  high in every state except S_IDLE; done  out  1  one-cycle pulse when all kernels finish; err  out  1  sticky channel-count mismatch flag.

Function
REQ-015 FSM states SHALL be S_IDLE, S_LOAD_REQ, S_LOAD_WAIT, S_MAC_START, S_MAC_WAIT, S_ADV_B, S_ADV_WAIT, S_OUT, S_DONE.
REQ-016 S_IDLE: on start with num_kernels!=0 and CHANNEL_SIZE!=0 -> S_LOAD_REQ; clear kernel counter, channel counter, accumulator, last flag; with either field zero -> S_DONE and set err.
REQ-017 S_LOAD_REQ SHALL assert load_BRAM_dina for exactly one cycle, then -> S_LOAD_WAIT.
REQ-018 S_LOAD_WAIT SHALL remain until done_loading_1ker=1, then -> S_MAC_START.
REQ-019 S_MAC_START SHALL assert mac_start for one cycle, then -> S_MAC_WAIT.
REQ-020 S_MAC_WAIT: on mac_done, acc <= acc + sign-extended mac_result, wrapping modulo 2^ACC_W, no saturation; increment channel counter; -> S_ADV_B.
REQ-021 S_ADV_B SHALL assert update_BRAM_doutb for one cycle, load a 3-bit wait counter with 3, then -> S_ADV_WAIT.
REQ-022 During S_ADV_B and S_ADV_WAIT, any cycle with last_channel=1 SHALL set the sticky last flag.
REQ-023 S_ADV_WAIT SHALL decrement the wait counter and leave when it reaches 0: last flag set -> S_OUT; else if channel counter == CHANNEL_SIZE -> set err, -> S_OUT; else -> S_MAC_START.
REQ-024 If the last flag is set while channel counter != CHANNEL_SIZE, err SHALL be set; S_OUT still follows.
REQ-025 S_OUT SHALL hold out_valid=1 and out_data=acc stable until out_ready=1; on that cycle increment the kernel counter, clear acc, channel counter and last flag; -> S_DONE if kernel counter+1 == num_kernels, else -> S_LOAD_REQ.
REQ-026 S_DONE SHALL pulse done for one cycle, then -> S_IDLE; err persists until the next accepted start.
REQ-027 All control outputs SHALL be decoded from the registered state only; no input-to-output combinational path except none.
REQ-028 mac_done outside S_MAC_WAIT and done_loading_1ker outside S_LOAD_WAIT SHALL be ignored.

Reset
REQ-029 Reset=1 on any clock edge SHALL force S_IDLE regardless of state; all pulses stop in the same edge.
REQ-030 After reset: load_BRAM_dina, update_BRAM_doutb, mac_start, out_valid, busy, done and err = 0; out_data, acc and all counters = 0.

Structure
REQ-031 State encodings, MAC_W/ACC_W defaults and the post-advance wait constant 3 SHALL live in the shared package conv_pkg.
REQ-032 The accumulator SHALL be one sub-module, conv_chan_acc: clear, add-enable, registered ACC_W-bit sum.

Verification
REQ-033 CHANNEL_SIZE=3, num_kernels=1, mac_result 5,-2,7, last_channel asserted 2 cycles after the 3rd update -> three mac_start pulses, out_data=10, one done.
REQ-034 num_kernels=2, CHANNEL_SIZE=1 -> two load_BRAM_dina pulses, each issued only after the previous out_valid/out_ready handshake; two outputs, err=0.
REQ-035 out_ready held 0 for 5 cycles in S_OUT -> out_valid and out_data stable for all 5 cycles; no load_BRAM_dina pulse.
REQ-036 last_channel never asserted with CHANNEL_SIZE=2 -> after the 2nd channel err=1, S_OUT entered, done pulses.
REQ-037 Reset=1 asserted in S_MAC_WAIT -> next cycle all outputs 0 and busy=0; a fresh start completes normally.
REQ-038 mac_result = max positive with ACC_W=MAC_W -> accumulator wraps to negative, no err.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution channel sequencer: FSM encoding,
// default datapath widths and the settle time after a BRAM read advance.
package conv_pkg;

    localparam int MAC_W_DEF = 32;
    localparam int ACC_W_DEF = 40;

    // Cycles spent in S_ADV_WAIT so last_channel has time to come back.
    localparam logic [2:0] ADV_WAIT_CYC = 3'd3;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_LOAD_REQ  = 4'd1,
        S_LOAD_WAIT = 4'd2,
        S_MAC_START = 4'd3,
        S_MAC_WAIT  = 4'd4,
        S_ADV_B     = 4'd5,
        S_ADV_WAIT  = 4'd6,
        S_OUT       = 4'd7,
        S_DONE      = 4'd8
    } state_t;

endpackage

// File: rtl/conv_channel_seq_if.sv
// Bundle of control, MAC and output-handshake signals between the channel
// sequencer (slave side) and its surroundings (master side).
interface conv_channel_seq_if
    import conv_pkg::*;
#(
    parameter int MAC_W = MAC_W_DEF,
    parameter int ACC_W = ACC_W_DEF
);
    logic                    start;
    logic [8:0]              num_kernels;
    logic [8:0]              CHANNEL_SIZE;
    logic                    load_BRAM_dina;
    logic                    done_loading_1ker;
    logic                    update_BRAM_doutb;
    logic                    last_channel;
    logic                    mac_start;
    logic                    mac_done;
    logic signed [MAC_W-1:0] mac_result;
    logic                    out_valid;
    logic                    out_ready;
    logic [ACC_W-1:0]        out_data;
    logic                    busy;
    logic                    done;
    logic                    err;

    modport master (
        output start, num_kernels, CHANNEL_SIZE, done_loading_1ker, last_channel,
               mac_done, mac_result, out_ready,
        input  load_BRAM_dina, update_BRAM_doutb, mac_start, out_valid, out_data,
               busy, done, err
    );

    modport slave (
        input  start, num_kernels, CHANNEL_SIZE, done_loading_1ker, last_channel,
               mac_done, mac_result, out_ready,
        output load_BRAM_dina, update_BRAM_doutb, mac_start, out_valid, out_data,
               busy, done, err
    );
endinterface

// File: rtl/conv_chan_acc.sv
// Per-kernel channel accumulator: sign-extends each MAC partial sum and adds
// it into a wrapping ACC_W-bit register; clear has priority over add.
module conv_chan_acc
    import conv_pkg::*;
#(
    parameter int MAC_W = MAC_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clr,
    input  logic                    i_add_en,
    input  logic signed [MAC_W-1:0] i_addend,
    output logic [ACC_W-1:0]        o_acc
);
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_addend_ext;

    assign w_addend_ext = ACC_W'(i_addend);
    assign o_acc        = r_acc;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc <= '0;
        end else if (i_add_en) begin
            r_acc <= r_acc + w_addend_ext;
        end
    end
endmodule

// File: rtl/conv_channel_seq.sv
// Sequences kernel load, per-channel MAC and BRAM read advance for each output
// kernel, accumulating channel partial sums and handing the result out.
module conv_channel_seq
    import conv_pkg::*;
#(
    parameter int MAC_W = MAC_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              Reset,
    conv_channel_seq_if.slave bus
);
    state_t           r_state, w_state_nxt;
    logic [8:0]       r_num_k, r_chan_sz, r_kern_cnt, r_chan_cnt;
    logic [2:0]       r_wait;
    logic             r_last, r_err;
    logic             w_accept, w_last_now, w_wait_end, w_chan_full;
    logic             w_acc_clr, w_acc_add, w_out_take;
    logic [ACC_W-1:0] w_acc;

    assign w_accept    = (r_state == S_IDLE) && bus.start;
    assign w_last_now  = r_last || bus.last_channel;
    assign w_wait_end  = (r_wait <= 3'd1);
    assign w_chan_full = (r_chan_cnt == r_chan_sz);
    assign w_out_take  = (r_state == S_OUT) && bus.out_ready;
    assign w_acc_clr   = w_accept || w_out_take;
    assign w_acc_add   = (r_state == S_MAC_WAIT) && bus.mac_done;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (bus.start)
                             w_state_nxt = (bus.num_kernels != 9'd0 && bus.CHANNEL_SIZE != 9'd0)
                                           ? S_LOAD_REQ : S_DONE;
            S_LOAD_REQ:  w_state_nxt = S_LOAD_WAIT;
            S_LOAD_WAIT: if (bus.done_loading_1ker) w_state_nxt = S_MAC_START;
            S_MAC_START: w_state_nxt = S_MAC_WAIT;
            S_MAC_WAIT:  if (bus.mac_done) w_state_nxt = S_ADV_B;
            S_ADV_B:     w_state_nxt = S_ADV_WAIT;
            S_ADV_WAIT:  if (w_wait_end)
                             w_state_nxt = (w_last_now || w_chan_full) ? S_OUT : S_MAC_START;
            S_OUT:       if (bus.out_ready)
                             w_state_nxt = (r_kern_cnt + 9'd1 == r_num_k) ? S_DONE : S_LOAD_REQ;
            S_DONE:      w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_num_k    <= '0;
            r_chan_sz  <= '0;
            r_kern_cnt <= '0;
            r_chan_cnt <= '0;
            r_wait     <= '0;
            r_last     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_num_k    <= bus.num_kernels;
                    r_chan_sz  <= bus.CHANNEL_SIZE;
                    r_kern_cnt <= '0;
                    r_chan_cnt <= '0;
                    r_last     <= 1'b0;
                    r_err      <= (bus.num_kernels == 9'd0) || (bus.CHANNEL_SIZE == 9'd0);
                end
                S_MAC_WAIT: if (bus.mac_done) r_chan_cnt <= r_chan_cnt + 9'd1;
                S_ADV_B: begin
                    r_wait <= ADV_WAIT_CYC;
                    if (bus.last_channel) r_last <= 1'b1;
                end
                S_ADV_WAIT: begin
                    r_wait <= r_wait - 3'd1;
                    if (bus.last_channel) r_last <= 1'b1;
                    // Channel count and last flag must agree when the kernel ends.
                    if (w_wait_end && (w_last_now != w_chan_full)) r_err <= 1'b1;
                end
                S_OUT: if (bus.out_ready) begin
                    r_kern_cnt <= r_kern_cnt + 9'd1;
                    r_chan_cnt <= '0;
                    r_last     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    conv_chan_acc #(.MAC_W(MAC_W), .ACC_W(ACC_W)) u_acc (
        .clk      (clk),
        .rst      (Reset),
        .i_clr    (w_acc_clr),
        .i_add_en (w_acc_add),
        .i_addend (bus.mac_result),
        .o_acc    (w_acc)
    );

    assign bus.load_BRAM_dina    = (r_state == S_LOAD_REQ);
    assign bus.update_BRAM_doutb = (r_state == S_ADV_B);
    assign bus.mac_start         = (r_state == S_MAC_START);
    assign bus.out_valid         = (r_state == S_OUT);
    assign bus.busy              = (r_state != S_IDLE);
    assign bus.done              = (r_state == S_DONE);
    assign bus.err               = r_err;
    assign bus.out_data          = w_acc;
endmodule
